// File: rtl/dds_sweep_gen.sv
// rtl/dds_sweep_gen.sv - DDS tuning-word sweep sequencer (start->stop, per-word dwell, single/continuous)
module dds_sweep_gen #(
   parameter int INC_BITS   = 32,
   parameter int DWELL_BITS = 32
) (
   input  logic                  rst,
   input  logic                  out_clk,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic                  hold_i,
   input  logic                  mode_i,
   input  logic [INC_BITS-1:0]   f_start_i,
   input  logic [INC_BITS-1:0]   f_stop_i,
   input  logic [INC_BITS-1:0]   f_step_i,
   input  logic [DWELL_BITS-1:0] dwell_i,
   output logic [INC_BITS-1:0]   inc_out,
   output logic                  sync_o,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                state, state_n;
   logic [INC_BITS-1:0]   f_start_q, f_stop_q, f_step_q;
   logic [DWELL_BITS-1:0] dwell_q, dcnt, dcnt_n;
   logic                  mode_q, dir_q;
   logic [INC_BITS-1:0]   inc_n;
   logic                  sync_n, done_n, load_cfg;
   logic [INC_BITS:0]     sum_up, sum_dn;
   logic                  passed, at_end;

   always_comb begin
      // One extra bit so a step past either end of the range is seen, never wrapped
      sum_up = {1'b0, inc_out} + {1'b0, f_step_q};
      sum_dn = {1'b0, inc_out} - {1'b0, f_step_q};
      passed = dir_q ? (sum_up > {1'b0, f_stop_q})
                     : (sum_dn[INC_BITS] || (sum_dn[INC_BITS-1:0] < f_stop_q));
      // A zero step makes the sweep a single point
      at_end = (inc_out == f_stop_q) || (f_step_q == '0);
   end

   always_comb begin
      state_n  = state;
      dcnt_n   = dcnt;
      inc_n    = inc_out;
      sync_n   = 1'b0;
      done_n   = 1'b0;
      load_cfg = 1'b0;
      if (stop_i) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  load_cfg = 1'b1;
                  state_n  = RUN;
                  inc_n    = f_start_i;
                  sync_n   = 1'b1;
                  dcnt_n   = dwell_i;
               end
            end
            RUN: begin
               if (hold_i) begin
                  state_n = RUN;
               end else if (dcnt != '0) begin
                  dcnt_n = dcnt - 1'b1;
               end else if (!at_end) begin
                  inc_n  = passed ? f_stop_q
                                  : (dir_q ? sum_up[INC_BITS-1:0] : sum_dn[INC_BITS-1:0]);
                  dcnt_n = dwell_q;
               end else if (mode_q) begin
                  inc_n  = f_start_q;
                  sync_n = 1'b1;
                  dcnt_n = dwell_q;
               end else begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge out_clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         dcnt      <= '0;
         inc_out   <= '0;
         sync_o    <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         f_start_q <= '0;
         f_stop_q  <= '0;
         f_step_q  <= '0;
         dwell_q   <= '0;
         mode_q    <= 1'b0;
         dir_q     <= 1'b1;
      end else begin
         state   <= state_n;
         dcnt    <= dcnt_n;
         inc_out <= inc_n;
         sync_o  <= sync_n;
         done_o  <= done_n;
         busy_o  <= (state_n == RUN);
         if (load_cfg) begin
            f_start_q <= f_start_i;
            f_stop_q  <= f_stop_i;
            f_step_q  <= f_step_i;
            dwell_q   <= dwell_i;
            mode_q    <= mode_i;
            dir_q     <= (f_stop_i >= f_start_i);
         end
      end
   end

endmodule

// File: tb/tb_dds_sweep_gen.sv
// tb/tb_dds_sweep_gen.sv - scoreboard bench for dds_sweep_gen against a word-list sweep model
module tb_dds_sweep_gen;

   typedef struct packed {
      logic [31:0] inc;
      logic        sync;
      logic        busy;
      logic        done;
   } out_t;

   logic        rst, out_clk;
   logic        start_i, stop_i, hold_i, mode_i;
   logic [31:0] f_start_i, f_stop_i, f_step_i, dwell_i;
   logic [31:0] inc_out;
   logic        sync_o, busy_o, done_o;

   out_t exp_q[$];
   out_t cur;
   int   n_checks = 0;
   int   n_fail   = 0;

   dds_sweep_gen dut (
      .rst(rst), .out_clk(out_clk), .start_i(start_i), .stop_i(stop_i),
      .hold_i(hold_i), .mode_i(mode_i), .f_start_i(f_start_i), .f_stop_i(f_stop_i),
      .f_step_i(f_step_i), .dwell_i(dwell_i), .inc_out(inc_out), .sync_o(sync_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   initial begin
      out_clk = 1'b0;
      forever #5 out_clk = ~out_clk;
   end

   function automatic out_t mk(input logic [31:0] inc, input logic s, input logic b, input logic d);
      out_t o;
      o.inc = inc; o.sync = s; o.busy = b; o.done = d;
      return o;
   endfunction

   function automatic out_t dut_out();
      return mk(inc_out, sync_o, busy_o, done_o);
   endfunction

   task automatic check(input string name, input out_t got, input out_t want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s @%0t: got inc=%0h sync=%0b busy=%0b done=%0b, want inc=%0h sync=%0b busy=%0b done=%0b",
                  name, $time, got.inc, got.sync, got.busy, got.done,
                  want.inc, want.sync, want.busy, want.done);
      end
   endtask

   // Monitor: one registered output set per clock, checked on the falling edge
   initial begin
      out_t e;
      forever begin
         @(negedge out_clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", dut_out(), e);
         end
      end
   end

   task automatic step_cycle(input out_t e);
      @(posedge out_clk);
      #1;
      exp_q.push_back(e);
      cur = e;
      #1;
   endtask

   task automatic scramble();
      f_start_i = $urandom; f_stop_i = $urandom; f_step_i = $urandom;
      dwell_i = $urandom; mode_i = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      #4;
      rst = 1'b0;
      #1;
      check("reset_async", dut_out(), mk(32'd0, 1'b0, 1'b0, 1'b0));
      @(posedge out_clk);
      #2;
      check("reset_held", dut_out(), mk(32'd0, 1'b0, 1'b0, 1'b0));
      rst = 1'b1;
      step_cycle(mk(32'd0, 1'b0, 1'b0, 1'b0));
   endtask

   // Model: list the distinct tuning words, expand by dwell, then drive with hold/stop/reset overlays
   task automatic run_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                            input int dw, input logic md, input int hold_at, input int hold_len,
                            input int stop_at, input int rst_at);
      longint      wl[$];
      out_t        seq[$];
      longint      ls, le, lst, w;
      logic [31:0] word;
      int          p;
      ls = longint'(s); le = longint'(e); lst = longint'(st);
      w = ls;
      wl.push_back(w);
      if (lst != 0) begin
         while (w != le) begin
            if (le >= ls) w = (w + lst > le) ? le : w + lst;
            else          w = (w - lst < le) ? le : w - lst;
            wl.push_back(w);
         end
      end
      do begin
         foreach (wl[i]) begin
            word = 32'(wl[i]);
            for (int k = 0; k <= dw; k++) seq.push_back(mk(word, (i == 0 && k == 0), 1'b1, 1'b0));
         end
      end while (md && seq.size() < stop_at + hold_len + 5);
      if (!md) seq.push_back(mk(seq[seq.size()-1].inc, 1'b0, 1'b0, 1'b1));

      f_start_i = s; f_stop_i = e; f_step_i = st; dwell_i = 32'(dw); mode_i = md;
      start_i = 1'b1;
      step_cycle(seq[0]);
      start_i = 1'b0;
      scramble();
      p = 1;
      for (int c = 1; p < seq.size(); c++) begin
         if (c == rst_at) begin
            do_reset();
            return;
         end
         if (c == stop_at) begin
            stop_i = 1'b1;
            step_cycle(mk(cur.inc, 1'b0, 1'b0, 1'b0));
            stop_i = 1'b0;
            break;
         end
         if (c >= hold_at && c < hold_at + hold_len) begin
            hold_i = 1'b1;
            step_cycle(mk(cur.inc, 1'b0, 1'b1, 1'b0));
            hold_i = 1'b0;
         end else begin
            step_cycle(seq[p]);
            p++;
         end
      end
      step_cycle(mk(cur.inc, 1'b0, 1'b0, 1'b0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running, want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int          r, dw, hl, ha, sa;
      logic        md;
      logic [31:0] base, s, e, st;
      rst = 1'b0; start_i = 1'b0; stop_i = 1'b0; hold_i = 1'b0; mode_i = 1'b0;
      f_start_i = '0; f_stop_i = '0; f_step_i = '0; dwell_i = '0;
      cur = mk(32'd0, 1'b0, 1'b0, 1'b0);
      #12;
      check("reset_state", dut_out(), mk(32'd0, 1'b0, 1'b0, 1'b0));
      #10;
      rst = 1'b1;
      step_cycle(mk(32'd0, 1'b0, 1'b0, 1'b0));
      step_cycle(mk(32'd0, 1'b0, 1'b0, 1'b0));

      run_sweep(32'd100, 32'd130, 32'd10, 2, 1'b0, -1, 0, -1, -1);
      run_sweep(32'd100, 32'd125, 32'd10, 0, 1'b0, -1, 0, -1, -1);
      run_sweep(32'd130, 32'd100, 32'd20, 0, 1'b0, -1, 0, -1, -1);
      run_sweep(32'hFFFFFFF0, 32'hFFFFFFFF, 32'h10, 1, 1'b0, -1, 0, -1, -1);
      run_sweep(32'd5, 32'd0, 32'd10, 0, 1'b0, -1, 0, -1, -1);
      run_sweep(32'd5, 32'd7, 32'd1, 0, 1'b1, -1, 0, 14, -1);
      run_sweep(32'd100, 32'd130, 32'd10, 2, 1'b0, 4, 4, -1, -1);
      run_sweep(32'd100, 32'd130, 32'd10, 2, 1'b0, -1, 0, 4, -1);

      f_start_i = 32'd77; f_stop_i = 32'd90; f_step_i = 32'd1; dwell_i = 32'd0;
      start_i = 1'b1; stop_i = 1'b1;
      step_cycle(mk(cur.inc, 1'b0, 1'b0, 1'b0));
      step_cycle(mk(cur.inc, 1'b0, 1'b0, 1'b0));
      start_i = 1'b0; stop_i = 1'b0;

      run_sweep(32'd50, 32'd80, 32'd0, 3, 1'b0, -1, 0, -1, 3);
      run_sweep(32'd50, 32'd80, 32'd0, 3, 1'b0, -1, 0, -1, -1);
      run_sweep(32'd50, 32'd80, 32'd0, 1, 1'b1, -1, 0, 9, -1);

      for (int i = 0; i < 20; i++) begin
         r = int'($urandom_range(0, 2));
         base = (r == 0) ? 32'd0 : (r == 1) ? 32'hFFFFFF00 : ($urandom & 32'h7FFFFFFF);
         s  = base + $urandom_range(0, 255);
         e  = base + $urandom_range(0, 255);
         st = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 80));
         dw = int'($urandom_range(0, 2));
         md = 1'($urandom_range(0, 1));
         ha = int'($urandom_range(1, 8));
         hl = int'($urandom_range(0, 3));
         sa = md ? int'($urandom_range(6, 40))
                 : (($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 10)) : -1);
         run_sweep(s, e, st, dw, md, ha, hl, sa, -1);
      end

      #30;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dds_sweep_gen.md
# dds_sweep_gen

Frequency-sweep sequencer that drives the DDS phase accumulator's tuning-word and sync inputs. It steps a tuning word from a start to a stop frequency, holding each value for a programmable number of clocks. It runs in single-shot or continuous mode and pulses sync at every sweep start so the accumulator phase restarts at zero. It sits directly upstream of the phase accumulator in the out_clk domain of the RePLIA DDS chain.

## Interface
- INC_BITS, 32, tuning-word width; equals the accumulator increment width
- DWELL_BITS, 32, dwell counter width
- rst  in  1  asynchronous, active-low reset
- out_clk  in  1  DDS clock; all logic is on its rising edge
- start_i  in  1  level, sampled only in IDLE; begins a sweep
- stop_i  in  1  abort; has priority over start_i and hold_i
- hold_i  in  1  freezes the sweep (dwell counter and inc_out) while high
- mode_i  in  1  0 = single-shot, 1 = continuous; latched at start
- f_start_i  in  INC_BITS  first tuning word; latched at start
- f_stop_i  in  INC_BITS  last tuning word; latched at start
- f_step_i  in  INC_BITS  step magnitude, unsigned; latched at start
- dwell_i  in  DWELL_BITS  each word is held for dwell_i+1 clocks; latched at start
- inc_out  out  INC_BITS  tuning word to the accumulator inc_in
- sync_o  out  1  one-cycle pulse to the accumulator sync_i
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle pulse at the end of a single-shot sweep

## Operation
- States:
  - IDLE: inc_out holds its last value.
  - RUN: the dwell counter `dcnt` decrements each clock; `dir` = 1 (up) when f_stop ≥ f_start, else 0 (down).
- IDLE→RUN: start_i=1 and stop_i=0. Latch all configuration, set inc_out=f_start, pulse sync_o, set dcnt=dwell.
- RUN with hold_i=1: dcnt, inc_out and state are frozen; no sync_o or done_o.
- RUN with dcnt≠0: dcnt decrements.
- RUN with dcnt=0 and inc_out≠f_stop:
  - Compute nxt = inc_out ± f_step in INC_BITS+1 bits.
  - If nxt passes f_stop (up: nxt > f_stop, down: nxt < f_stop or underflow), clamp inc_out to f_stop; otherwise inc_out = nxt.
  - Reload dcnt=dwell.
- RUN with dcnt=0 and inc_out=f_stop:
  - Single-shot: go to IDLE, pulse done_o, inc_out holds f_stop.
  - Continuous: inc_out=f_start, pulse sync_o, reload dcnt, stay in RUN.
- f_step=0 or f_start=f_stop: a single point. f_start is held dwell+1 clocks, then end-of-sweep handling applies.
- stop_i=1 in any state: go to IDLE next clock; inc_out unchanged; no done_o, no sync_o.
- The tuning word never wraps modulo 2^INC_BITS; clamping is always to f_stop.
- Configuration inputs are ignored while in RUN.

## Timing
- Reset values: inc_out=0, sync_o=0, busy_o=0, done_o=0, state IDLE, dcnt=0.
- All outputs are registered.
- Start latency: start_i sampled high at edge N (in IDLE) gives inc_out=f_start, sync_o=1 and busy_o=1 after edge N.
- Each tuning word is visible for exactly dwell+1 clocks, plus any hold_i cycles.
- Single-shot end: done_o=1 and busy_o=0 in the cycle after the last f_stop cycle.
- Continuous wrap: f_start and sync_o appear in the cycle after the last f_stop cycle, with no gap.
- sync_o coincides with the first cycle of f_start on inc_out. The accumulator's two-stage inc pipeline keeps the phase reset and the new word aligned.
- Simultaneous events: stop_i beats start_i and hold_i in the same cycle. A start_i held high through a single-shot done restarts one cycle after done_o, i.e. from IDLE.
- A reset asserted mid-sweep immediately forces the reset values.

## Test plan
- Up sweep, single-shot: f_start=100, f_stop=130, step=10, dwell=2 → inc_out 100,110,120,130, each for 3 clocks. sync_o on the first cycle of 100; done_o one cycle after the last 130; busy_o high for 12 cycles.
- Clamp and down sweep:
  - start=100, stop=125, step=10, dwell=0 → 100,110,120,125.
  - start=130, stop=100, step=20, dwell=0 → 130,110,100.
- Overflow guard: start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x10, dwell=1 → 0xFFFFFFF0 ×2, then 0xFFFFFFFF ×2, then done. No wrap to 0.
- Continuous mode: start=5, stop=7, step=1, dwell=0 → 5,6,7,5,6,7…; sync_o each cycle inc_out=5; done_o never asserted.
- Hold and stop:
  - hold_i for 4 cycles mid-dwell → that word lasts dwell+1+4 clocks.
  - stop_i at value 110 → IDLE next cycle, inc_out stays 110, done_o=0.
  - stop_i and start_i high together in IDLE → remains IDLE.
- Reset mid-sweep, and step=0 (start=50, dwell=3) → reset forces all outputs to 0 immediately. With step=0, 50 is held 4 clocks, then done_o.
